// File: rtl/stage_ctrl.sv
// stage_ctrl: typing-game stage sequencer driving the boss-timer start enable,
// stage code, lives and win/game-over status.
module stage_ctrl #(
    parameter int TICK_DIV      = 2500000,
    parameter int INTRO_TICKS   = 4,
    parameter int HIT_PER_STAGE = 20,
    parameter int BOSS_STAGE    = 3,
    parameter int MAX_STAGE     = 5,
    parameter int LIVES         = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_start,
    input  logic       hit,
    input  logic       miss,
    input  logic       boss_pause,
    output logic [4:0] boss,
    output logic       start,
    output logic [2:0] lives,
    output logic       stage_clr,
    output logic       game_over,
    output logic       win
);
    localparam int DW = $clog2(TICK_DIV + 1);
    localparam int TW = $clog2(INTRO_TICKS + 1);
    localparam int HW = $clog2(HIT_PER_STAGE + 1);

    typedef enum logic [2:0] {IDLE, INTRO, PLAY, BOSS, OVER, WIN} state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   div_q, div_d;
    logic [TW-1:0]   ticks_q, ticks_d;
    logic [HW-1:0]   hits_q, hits_d;
    logic            armed_q, armed_d;
    logic [4:0]      boss_q, boss_d;
    logic            start_q, start_d;
    logic [2:0]      lives_q, lives_d;
    logic            clr_q, clr_d;
    logic            over_q, over_d;
    logic            win_q, win_d;

    logic tick, intro_done, running, miss_v, dead, clear, restart, last, enter_intro;

    always_comb begin
        tick       = div_q == DW'(TICK_DIV - 1);
        intro_done = state_q == INTRO && tick && ticks_q == TW'(INTRO_TICKS - 1);
        running    = state_q == PLAY || state_q == BOSS;
        miss_v     = running && miss;
        // a fatal miss beats any clear landing in the same cycle
        dead       = miss_v && lives_q == 3'd1;
        clear      = !dead && ((state_q == PLAY && hit && hits_q == HW'(HIT_PER_STAGE - 1)) ||
                               (state_q == BOSS && armed_q && boss_pause));
        restart    = key_start && (state_q == IDLE || state_q == OVER || state_q == WIN);
        last       = boss_q == 5'(MAX_STAGE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (restart)
            state_d = INTRO;
        else if (intro_done)
            state_d = boss_q == 5'(BOSS_STAGE) ? BOSS : PLAY;
        else if (dead)
            state_d = OVER;
        else if (clear)
            state_d = last ? WIN : INTRO;
    end

    always_comb begin
        enter_intro = state_d == INTRO && state_q != INTRO;
        div_d       = (enter_intro || tick) ? '0 : div_q + DW'(1);
        ticks_d     = enter_intro ? '0 : (state_q == INTRO && tick) ? ticks_q + TW'(1) : ticks_q;
        hits_d      = (restart || clear) ? '0 :
                      (state_q == PLAY && hit && hits_q != HW'(HIT_PER_STAGE)) ? hits_q + HW'(1) : hits_q;
        // the timer's first-cycle pause is latency, so only a pause after a low counts
        armed_d     = (restart || clear) ? 1'b0 : (state_q == BOSS && !boss_pause) ? 1'b1 : armed_q;
        boss_d      = restart ? 5'd1 : (clear && !last) ? boss_q + 5'd1 : boss_q;
        start_d     = intro_done ? 1'b1 : (dead || clear || restart) ? 1'b0 : start_q;
        lives_d     = restart ? 3'(LIVES) : miss_v ? lives_q - 3'd1 : lives_q;
        clr_d       = clear;
        over_d      = restart ? 1'b0 : dead ? 1'b1 : over_q;
        win_d       = restart ? 1'b0 : (clear && last) ? 1'b1 : win_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q   <= '0;
            ticks_q <= '0;
            hits_q  <= '0;
            armed_q <= 1'b0;
            boss_q  <= 5'd0;
            start_q <= 1'b0;
            lives_q <= 3'(LIVES);
            clr_q   <= 1'b0;
            over_q  <= 1'b0;
            win_q   <= 1'b0;
        end else begin
            div_q   <= div_d;
            ticks_q <= ticks_d;
            hits_q  <= hits_d;
            armed_q <= armed_d;
            boss_q  <= boss_d;
            start_q <= start_d;
            lives_q <= lives_d;
            clr_q   <= clr_d;
            over_q  <= over_d;
            win_q   <= win_d;
        end
    end

    assign boss      = boss_q;
    assign start     = start_q;
    assign lives     = lives_q;
    assign stage_clr = clr_q;
    assign game_over = over_q;
    assign win       = win_q;
endmodule

// File: tb/tb_stage_ctrl.sv
// tb_stage_ctrl: directed game scenarios checked against a clock-level game model
// plus literal expectations at the key moments of each scenario.
module tb_stage_ctrl;
    localparam int TICK_DIV = 4, INTRO_TICKS = 2, HPS = 3, BOSS_STAGE = 3, MAX_STAGE = 4, LIVES = 3;
    localparam int P_IDLE = 0, P_INTRO = 1, P_PLAY = 2, P_BOSS = 3, P_OVER = 4, P_WIN = 5;

    logic clk = 0, rst = 0, key_start = 0, hit = 0, miss = 0, boss_pause = 1;
    logic [4:0] boss;
    logic       start;
    logic [2:0] lives;
    logic       stage_clr, game_over, win;
    logic       go = 0;

    int n_checks = 0, n_fail = 0;
    int m_phase, m_boss, m_start, m_lives, m_clr, m_over, m_win, m_hits, m_armed, m_left;

    stage_ctrl #(
        .TICK_DIV(TICK_DIV), .INTRO_TICKS(INTRO_TICKS), .HIT_PER_STAGE(HPS),
        .BOSS_STAGE(BOSS_STAGE), .MAX_STAGE(MAX_STAGE), .LIVES(LIVES)
    ) dut (
        .clk(clk), .rst(rst), .key_start(key_start), .hit(hit), .miss(miss),
        .boss_pause(boss_pause), .boss(boss), .start(start), .lives(lives),
        .stage_clr(stage_clr), .game_over(game_over), .win(win)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE; m_boss = 0; m_start = 0; m_lives = LIVES; m_clr = 0;
        m_over = 0; m_win = 0; m_hits = 0; m_armed = 0; m_left = 0;
    endtask

    task automatic new_game();
        m_boss = 1; m_lives = LIVES; m_hits = 0; m_armed = 0; m_over = 0; m_win = 0;
        m_start = 0; m_phase = P_INTRO; m_left = INTRO_TICKS * TICK_DIV;
    endtask

    // Intro is modelled as a plain clock countdown rather than a tick divider.
    task automatic model_step();
        int done;
        m_clr = 0;
        if (m_phase == P_IDLE || m_phase == P_OVER || m_phase == P_WIN) begin
            if (key_start) new_game();
        end else if (m_phase == P_INTRO) begin
            m_left--;
            if (m_left == 0) begin
                m_phase = (m_boss == BOSS_STAGE) ? P_BOSS : P_PLAY;
                m_start = 1;
            end
        end else begin
            done = (m_phase == P_PLAY) ? int'(hit && m_hits + 1 >= HPS) : int'(m_armed == 1 && boss_pause);
            if (m_phase == P_PLAY && hit) m_hits++;
            if (m_phase == P_BOSS && !boss_pause) m_armed = 1;
            if (miss) m_lives--;
            if (miss && m_lives == 0) begin
                m_phase = P_OVER; m_over = 1; m_start = 0;
            end else if (done != 0) begin
                m_clr = 1; m_start = 0; m_hits = 0; m_armed = 0;
                if (m_boss == MAX_STAGE) begin
                    m_phase = P_WIN; m_win = 1;
                end else begin
                    m_boss++; m_phase = P_INTRO; m_left = INTRO_TICKS * TICK_DIV;
                end
            end
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else model_step();
    end

    always @(negedge clk) begin
        if (go) begin
            chk("cyc_boss", int'(boss), m_boss);
            chk("cyc_start", int'(start), m_start);
            chk("cyc_lives", int'(lives), m_lives);
            chk("cyc_stage_clr", int'(stage_clr), m_clr);
            chk("cyc_game_over", int'(game_over), m_over);
            chk("cyc_win", int'(win), m_win);
        end
    end

    task automatic step(input logic ks, input logic h, input logic m, input logic bp);
        @(negedge clk);
        key_start = ks; hit = h; miss = m; boss_pause = bp;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic bp);
        for (int i = 0; i < n; i++) step(0, 0, 0, bp);
    endtask

    task automatic hits(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, 1);
    endtask

    initial begin
        #2 rst = 1;
        #1 go = 1;
        @(negedge clk); @(negedge clk);
        chk("rst_boss", int'(boss), 0);
        chk("rst_lives", int'(lives), 3);
        chk("rst_start", int'(start), 0);
        rst = 0;
        // 1: first stage
        step(1, 0, 0, 1);
        chk("s1_boss", int'(boss), 1);
        chk("s1_model_boss", m_boss, 1);
        for (int i = 0; i < 7; i++) begin
            step(0, 0, 0, 1);
            chk("s1_intro_start_low", int'(start), 0);
        end
        step(0, 0, 0, 1);
        chk("s1_play_start", int'(start), 1);
        hits(3);
        chk("s1_clr", int'(stage_clr), 1);
        chk("s1_boss2", int'(boss), 2);
        chk("s1_start_off", int'(start), 0);
        step(0, 0, 0, 1);
        chk("s1_clr_pulse", int'(stage_clr), 0);
        // 2: stage 2 then boss stage
        idle(7, 1);
        chk("s2_play", int'(start), 1);
        hits(3);
        chk("s2_boss3", int'(boss), 3);
        idle(8, 1);
        chk("s2_boss_start", int'(start), 1);
        step(0, 0, 0, 1);
        chk("s2_pause_latency", int'(stage_clr), 0);
        for (int i = 0; i < 20; i++) step(0, i % 4 == 1, 0, 0);
        chk("s2_hits_ignored", int'(boss), 3);
        chk("s2_no_clr", int'(stage_clr), 0);
        step(0, 0, 0, 1);
        chk("s2_boss_clr", int'(stage_clr), 1);
        chk("s2_boss4", int'(boss), 4);
        // 3: final stage and win
        idle(8, 1);
        chk("s3_play", int'(start), 1);
        hits(3);
        chk("s3_win", int'(win), 1);
        chk("s3_clr", int'(stage_clr), 1);
        chk("s3_boss_held", int'(boss), 4);
        chk("s3_model_win", m_win, 1);
        step(0, 1, 0, 1);
        step(0, 0, 1, 1);
        chk("s3_win_lives", int'(lives), 3);
        chk("s3_win_boss", int'(boss), 4);
        step(1, 0, 0, 1);
        chk("s3_restart_win", int'(win), 0);
        chk("s3_restart_boss", int'(boss), 1);
        chk("s3_restart_start", int'(start), 0);
        // 4: three misses
        idle(8, 1);
        step(0, 0, 1, 1);
        chk("s4_lives2", int'(lives), 2);
        step(0, 0, 1, 1);
        chk("s4_lives1", int'(lives), 1);
        step(0, 0, 1, 1);
        chk("s4_lives0", int'(lives), 0);
        chk("s4_over", int'(game_over), 1);
        chk("s4_start_off", int'(start), 0);
        step(0, 0, 1, 1);
        chk("s4_over_lives", int'(lives), 0);
        // 5: simultaneous hit and miss
        step(1, 0, 0, 1);
        chk("s5_restart_over", int'(game_over), 0);
        idle(8, 1);
        step(0, 0, 1, 1);
        step(0, 0, 1, 1);
        hits(2);
        step(0, 1, 1, 1);
        chk("s5_fatal_over", int'(game_over), 1);
        chk("s5_fatal_no_clr", int'(stage_clr), 0);
        step(1, 0, 0, 1);
        idle(8, 1);
        step(0, 0, 1, 1);
        hits(2);
        step(0, 1, 1, 1);
        chk("s5_lives1", int'(lives), 1);
        chk("s5_clr", int'(stage_clr), 1);
        chk("s5_boss2", int'(boss), 2);
        // 6: async reset mid-boss
        idle(8, 1);
        hits(3);
        idle(8, 1);
        idle(3, 0);
        chk("s6_in_boss", int'(boss), 3);
        #2 rst = 1;
        #1;
        chk("s6_async_boss", int'(boss), 0);
        chk("s6_async_start", int'(start), 0);
        chk("s6_async_lives", int'(lives), 3);
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 6; i++) step(0, 0, 0, i % 2 == 0);
        chk("s6_idle_boss", int'(boss), 0);
        chk("s6_idle_clr", int'(stage_clr), 0);
        step(1, 0, 0, 1);
        chk("s6_restart_boss", int'(boss), 1);
        step(0, 0, 0, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/stage_ctrl.md
Name: stage_ctrl

Overview:
- Game-progress sequencer for the typing game. It drives the 5-bit stage code `boss` and the `start` enable consumed directly downstream by the boss-stage survival timer.
- It advances stages on correct-keystroke counts and treats the boss stage as cleared when the downstream timer's `pause` output ends its run.
- It tracks player lives and signals game over or win.

Parameters:
- TICK_DIV, 2500000, clocks per game tick (same tick rate as the boss timer).
- INTRO_TICKS, 4, ticks spent in the pre-stage intro with start low.
- HIT_PER_STAGE, 20, correct hits needed to clear a normal stage.
- BOSS_STAGE, 3, stage code that is a boss stage.
- MAX_STAGE, 5, last stage code (1..31); clearing it wins the game.
- LIVES, 3, lives at game start (1..7).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- key_start  in  1  one-cycle pulse: player pressed start
- hit  in  1  one-cycle pulse: correct keystroke
- miss  in  1  one-cycle pulse: wrong key or character escaped
- boss_pause  in  1  pause output of the downstream boss timer
- boss  out  5  current stage code (0 = no game)
- start  out  1  stage running; feeds the boss timer's start input
- lives  out  3  remaining lives
- stage_clr  out  1  one-cycle pulse on stage cleared
- game_over  out  1  level: lives exhausted
- win  out  1  level: MAX_STAGE cleared

Behaviour:
- Reset values: boss=0, start=0, lives=LIVES, stage_clr=0, game_over=0, win=0, state=IDLE, hit counter=0, tick divider=0, armed=0. Async reset overrides everything, including mid-stage.
- Tick divider:
  - Free-running 0..TICK_DIV-1; tick is asserted for one cycle at terminal count.
  - The divider is cleared on every entry to INTRO.
- States: IDLE, INTRO, PLAY, BOSS, OVER, WIN. All outputs are registered.
- IDLE: key_start -> boss=1, lives=LIVES, hit counter=0, go to INTRO.
- INTRO: start=0. After INTRO_TICKS ticks, set start=1 on the next cycle and enter BOSS if boss==BOSS_STAGE, else PLAY.
- PLAY: start=1.
  - Each hit increments the hit counter (width ceil(log2(HIT_PER_STAGE+1)), saturating).
  - Reaching HIT_PER_STAGE counts as a stage clear.
- BOSS: start=1. Hits are ignored for advancement.
  - armed is set on the first cycle boss_pause==0.
  - armed && boss_pause==1 counts as a stage clear. This is the downstream timer finishing its count.
  - boss_pause==1 before arming (the timer's first cycle of latency) is ignored.
- Stage clear (from PLAY or BOSS):
  - Pulse stage_clr for 1 cycle, start=0, clear the hit counter and armed.
  - If boss==MAX_STAGE: go to WIN with win=1 and boss held.
  - Otherwise: boss=boss+1 and go to INTRO.
- Miss (PLAY/BOSS only): lives decrements by 1.
  - When lives goes 1 -> 0: go to OVER with game_over=1, start=0, boss held.
  - Misses are ignored in IDLE, INTRO, OVER and WIN.
- Simultaneous hit and miss in PLAY: both are applied.
  - If the miss kills and the hit clears in the same cycle, the miss wins: OVER, no stage_clr.
  - Same rule in BOSS: a fatal miss takes priority over the boss clear.
- OVER/WIN: outputs hold.
  - key_start clears game_over/win, sets boss=1, lives=LIVES, and goes to INTRO (restart).
- key_start in INTRO/PLAY/BOSS is ignored.
- boss never exceeds MAX_STAGE; there is no wrap.

Test Plan:
All scenarios use TICK_DIV=4, INTRO_TICKS=2, HIT_PER_STAGE=3, BOSS_STAGE=3, MAX_STAGE=4, LIVES=3.
1. Reset then key_start -> boss=1, start=0 for 8 clk of INTRO, then start=1. 3 hits -> stage_clr pulse, boss=2, start=0.
2. From stage 2, 3 hits -> boss=3, INTRO, then start=1 in BOSS. Model boss_pause: 1 for 1 cycle, 0 for 20 cycles, then 1 -> stage_clr on the cycle after it goes 1, boss=4. Hits during BOSS produce no clear.
3. Stage 4, 3 hits -> win=1, start=0, boss stays 4. Further hits/misses produce no change. key_start -> win=0, boss=1, lives=3, INTRO.
4. Three misses in PLAY -> lives 3->2->1->0, game_over=1 on the third, start=0. Misses in OVER leave lives=0.
5. lives=1 and 2 hits done; hit+miss in the same cycle -> game_over=1, stage_clr stays 0. With lives=2, hit+miss in the same cycle -> lives=1, stage_clr=1, boss+1.
6. Assert rst asynchronously mid-BOSS (between clock edges) -> all outputs return to reset values immediately. boss_pause toggles afterward produce no effect until key_start.
